// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the instruction/data memory arbiter
package mem_arbiter_pkg;

  typedef logic [31:0] bus32_t;

  typedef enum logic [1:0] {IDLE, INST, DATA, DONE} arb_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_INST, GNT_DATA} arb_grant_t;

  typedef struct packed {
    logic       we;
    bus32_t     addr;
    logic [3:0] sel;
    bus32_t     wdata;
  } mem_req_t;

  localparam bus32_t ARB_ERR_DATA = 32'hDEAD_BEEF;
  localparam int     STREAK_W     = 4;

endpackage

// File: rtl/mem_arbiter_prio_sel.sv
// rtl/mem_arbiter_prio_sel.sv - grant decision and streak update for one arbitration cycle
module mem_arbiter_prio_sel
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                inst_req,
  input  logic                data_req,
  input  logic [STREAK_W-1:0] streak,
  output arb_grant_t          grant,
  output logic [STREAK_W-1:0] streak_nxt
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_DATA_STREAK);

  always_comb begin
    grant      = GNT_NONE;
    streak_nxt = streak;
    // Data wins unless a waiting fetch has already watched MAX_DATA_STREAK data grants go by.
    if (data_req && !(inst_req && (streak >= MAX_STREAK))) begin
      grant = GNT_DATA;
      if (streak != '1) begin
        streak_nxt = streak + STREAK_W'(1);
      end
    end else if (inst_req) begin
      grant      = GNT_INST;
      streak_nxt = '0;
    end else begin
      streak_nxt = '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-ported memory between fetch and load/store ports
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  bus32_t      inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_valid,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_sel,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        arb_err
);

  if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 127) begin : g_param_check
    $error("mem_arbiter: parameter out of range");
  end

  arb_state_t          state_q, state_d;
  arb_grant_t          grant_q, grant_d;
  mem_req_t            req_q, req_d;
  logic                mem_req_q, mem_req_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [31:0]         inst_rdata_q, inst_rdata_d;
  logic [31:0]         data_rdata_q, data_rdata_d;
  logic                inst_valid_q, inst_valid_d;
  logic                data_valid_q, data_valid_d;

  arb_grant_t          sel_grant;
  logic [STREAK_W-1:0] sel_streak;

  mem_arbiter_prio_sel #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_prio_sel (
    .inst_req  (inst_req),
    .data_req  (data_req),
    .streak    (streak_q),
    .grant     (sel_grant),
    .streak_nxt(sel_streak)
  );

`ifdef ARB_TIMEOUT_EN
  logic [6:0] wd_q, wd_d;
  logic       arb_err_q, arb_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    req_d        = req_q;
    mem_req_d    = mem_req_q;
    streak_d     = streak_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_valid_d = 1'b0;
    data_valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wd_d         = wd_q;
    arb_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        streak_d = sel_streak;
        case (sel_grant)
          GNT_DATA: begin
            grant_d   = GNT_DATA;
            req_d     = '{we: data_we, addr: data_addr, sel: data_sel, wdata: data_wdata};
            mem_req_d = 1'b1;
            state_d   = DATA;
`ifdef ARB_TIMEOUT_EN
            wd_d      = '0;
`endif
          end
          GNT_INST: begin
            grant_d   = GNT_INST;
            req_d     = '{we: 1'b0, addr: inst_addr, sel: 4'hF, wdata: 32'h0};
            mem_req_d = 1'b1;
            state_d   = INST;
`ifdef ARB_TIMEOUT_EN
            wd_d      = '0;
`endif
          end
          default: ;
        endcase
      end
      INST, DATA: begin
        if (mem_ready) begin
          if (grant_q == GNT_INST) begin
            inst_rdata_d = mem_rdata;
            inst_valid_d = 1'b1;
          end else begin
            data_rdata_d = mem_rdata;
            data_valid_d = 1'b1;
          end
          mem_req_d = 1'b0;
          state_d   = DONE;
`ifdef ARB_TIMEOUT_EN
        end else if (wd_q == 7'(TIMEOUT_CYCLES - 1)) begin
          // Memory never answered: complete the access with a poison word and flag it.
          if (grant_q == GNT_INST) begin
            inst_rdata_d = ARB_ERR_DATA;
            inst_valid_d = 1'b1;
          end else begin
            data_rdata_d = ARB_ERR_DATA;
            data_valid_d = 1'b1;
          end
          arb_err_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else begin
          wd_d = wd_q + 7'd1;
`endif
        end
      end
      DONE: begin
        grant_d = GNT_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= GNT_NONE;
      req_q        <= '0;
      mem_req_q    <= 1'b0;
      streak_q     <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      req_q        <= req_d;
      mem_req_q    <= mem_req_d;
      streak_q     <= streak_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_valid_q <= inst_valid_d;
      data_valid_q <= data_valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      arb_err_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      arb_err_q <= arb_err_d;
    end
  end

  assign arb_err = arb_err_q;
`else
  assign arb_err = 1'b0;
`endif

  assign mem_req    = mem_req_q;
  assign mem_we     = req_q.we;
  assign mem_addr   = req_q.addr;
  assign mem_sel    = req_q.sel;
  assign mem_wdata  = req_q.wdata;
  assign inst_rdata = inst_rdata_q;
  assign inst_valid = inst_valid_q;
  assign data_rdata = data_rdata_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  bus32_t      inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_valid;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [3:0]  data_sel = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        arb_err;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_DATA_STREAK(MAX), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_valid(inst_valid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_sel(data_sel),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .arb_err(arb_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 = arbitrating, 1 = access outstanding, 2 = completion cycle
  int          ph = 0;
  int          win = 0;
  int          streak = 0;
  logic [31:0] e_irdata = '0, e_drdata = '0;
  logic        w_we;
  logic [31:0] w_addr, w_wdata;
  logic [3:0]  w_sel;
  bit          model_en = 1'b1;
  bit          auto_mem = 1'b1;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] next_rdata = '0;
  int          n_iv = 0, n_dv = 0;
  int          vseq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int exp_v;
    @(posedge clk);
    #1;
    if (inst_valid === 1'b1) begin n_iv++; vseq.push_back(1); end
    if (data_valid === 1'b1) begin n_dv++; vseq.push_back(2); end
    if (model_en) begin
      exp_v = 0;
      if (rst) begin
        ph = 0; streak = 0; e_irdata = '0; e_drdata = '0;
      end else begin
        case (ph)
          0: begin
            if (data_req && !(inst_req && streak >= MAX)) begin
              win = 2; streak = (streak < 15) ? streak + 1 : 15; ph = 1;
              w_we = data_we; w_addr = data_addr; w_sel = data_sel; w_wdata = data_wdata;
            end else if (inst_req) begin
              win = 1; streak = 0; ph = 1;
              w_we = 1'b0; w_addr = inst_addr; w_sel = 4'hF; w_wdata = '0;
            end else begin
              streak = 0;
            end
          end
          1: if (mem_ready) begin
            ph = 2; exp_v = win;
            if (win == 1) e_irdata = mem_rdata; else e_drdata = mem_rdata;
          end
          default: ph = 0;
        endcase
      end
      chk("mem_req", mem_req, ph == 1);
      if (ph == 1) begin
        chk("mem_we", mem_we, w_we);
        chk("mem_addr", mem_addr, w_addr);
        chk("mem_sel", mem_sel, w_sel);
        chk("mem_wdata", mem_wdata, w_wdata);
      end
      chk("inst_valid", inst_valid, exp_v == 1);
      chk("data_valid", data_valid, exp_v == 2);
      chk("inst_rdata", inst_rdata, e_irdata);
      chk("data_rdata", data_rdata, e_drdata);
      chk("arb_err", arb_err, 1'b0);
    end
    // Memory answers once mem_req has been high for more than mem_lat observed cycles
    if (mem_req && !mem_ready) begin
      mem_cnt++;
      if (auto_mem && mem_cnt > mem_lat) begin mem_ready = 1'b1; mem_rdata = next_rdata; end
    end else begin
      mem_ready = 1'b0; mem_cnt = 0;
    end
  endtask

  task automatic wait_valid(input int port, input int limit, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!((port == 1) ? inst_valid : data_valid) && cycles < limit);
    chk("wait_valid_bound", (port == 1) ? inst_valid : data_valid, 1'b1);
  endtask

  task automatic new_data();
    data_we = 1'($urandom); data_addr = $urandom; data_sel = 4'($urandom); data_wdata = $urandom;
  endtask

  initial begin
    int c;
    tick(); tick(); tick();
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_sel", mem_sel, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_we", mem_we, 32'h0);
    rst = 1'b0;
    tick();

    // Single fetch, 1-cycle memory
    n_iv = 0; n_dv = 0;
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; next_rdata = 32'h0280_0400; mem_lat = 1;
    wait_valid(1, 20, c);
    chk("fetch_latency_cycle", c + 1, 4);
    chk("fetch_rdata", inst_rdata, 32'h0280_0400);
    inst_req = 1'b0;
    tick(); tick();
    chk("fetch_iv_count", n_iv, 1);
    chk("fetch_dv_count", n_dv, 0);

    // Store held on the bus across a 2-cycle memory
    n_iv = 0; n_dv = 0;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_0010; data_sel = 4'b0011;
    data_wdata = 32'h1234_5678; next_rdata = $urandom; mem_lat = 2;
    wait_valid(2, 20, c);
    data_req = 1'b0;
    tick(); tick();
    chk("store_dv_count", n_dv, 1);
    chk("store_iv_count", n_iv, 0);

    // Simultaneous requests: data first, then inst
    vseq.delete(); mem_lat = 1;
    inst_req = 1'b1; inst_addr = 32'h1C00_0040; data_req = 1'b1; new_data();
    c = 0;
    while ((inst_req || data_req) && c < 40) begin
      next_rdata = $urandom;
      tick(); c++;
      if (inst_valid) inst_req = 1'b0;
      if (data_valid) data_req = 1'b0;
    end
    chk("simul_pulses", vseq.size(), 2);
    if (vseq.size() == 2) begin
      chk("simul_first", vseq[0], 2);
      chk("simul_second", vseq[1], 1);
    end
    tick();

    // Starvation bound: two rounds of four data grants then one fetch
    vseq.delete();
    inst_req = 1'b1; inst_addr = $urandom; data_req = 1'b1; new_data();
    c = 0;
    while (vseq.size() < 10 && c < 300) begin
      next_rdata = $urandom;
      tick(); c++;
      if (data_valid) new_data();
      if (inst_valid) inst_addr = $urandom;
    end
    inst_req = 1'b0; data_req = 1'b0;
    chk("starve_pulses", vseq.size(), 10);
    for (int i = 0; i < 10 && i < vseq.size(); i++)
      chk($sformatf("starve_order_%0d", i), vseq[i], (i % 5 == 4) ? 1 : 2);
    tick(); tick();

    // mem_ready while idle is ignored
    n_iv = 0; n_dv = 0;
    mem_ready = 1'b1; mem_rdata = $urandom;
    tick(); tick();
    chk("idle_ready_iv", n_iv, 0);
    chk("idle_ready_dv", n_dv, 0);

    // Reset in the middle of a data access
    n_dv = 0;
    data_req = 1'b1; new_data(); auto_mem = 1'b0;
    c = 0;
    while (!mem_req && c < 10) begin tick(); c++; end
    chk("rst_mid_granted", mem_req, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_dv", data_valid, 1'b0);
    rst = 1'b0; auto_mem = 1'b1; next_rdata = $urandom;
    wait_valid(2, 20, c);
    chk("rst_mid_dv_count", n_dv, 1);
    data_req = 1'b0;
    tick(); tick();

    // Randomized traffic with variable memory latency
    for (int i = 0; i < 3000; i++) begin
      next_rdata = $urandom;
      tick();
      if (!mem_req) mem_lat = $urandom_range(1, 3);
      if (inst_valid) begin
        inst_req = 1'($urandom); inst_addr = $urandom;
      end else if (!inst_req && $urandom_range(0, 3) == 0) begin
        inst_req = 1'b1; inst_addr = $urandom;
      end
      if (data_valid) begin
        data_req = 1'($urandom); new_data();
      end else if (!data_req && $urandom_range(0, 3) == 0) begin
        data_req = 1'b1; new_data();
      end
    end
    c = 0;
    while ((inst_req || data_req) && c < 100) begin
      tick(); c++;
      if (inst_valid) inst_req = 1'b0;
      if (data_valid) data_req = 1'b0;
    end
    chk("drain_done", inst_req | data_req, 1'b0);
    tick(); tick();

`ifdef ARB_TIMEOUT_EN
    model_en = 1'b0; auto_mem = 1'b0;
    data_req = 1'b1; new_data();
    c = 0;
    for (int i = 0; i < 200 && !data_valid; i++) begin
      tick();
      if (mem_req) c++;
    end
    chk("to_mem_req_cycles", c, 64);
    chk("to_data_valid", data_valid, 1'b1);
    chk("to_rdata", data_rdata, ARB_ERR_DATA);
    chk("to_arb_err", arb_err, 1'b1);
    chk("to_mem_req_low", mem_req, 1'b0);
    data_req = 1'b0;
    tick();
    chk("to_arb_err_pulse", arb_err, 1'b0);
    chk("to_dv_pulse", data_valid, 1'b0);
    auto_mem = 1'b1;
`else
    data_req = 1'b1; new_data(); auto_mem = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    auto_mem = 1'b1; next_rdata = $urandom;
    wait_valid(2, 20, c);
    data_req = 1'b0;
    tick(); tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
